// File: rtl/token_multiplier.sv
// Serial token expander: each token on a is replayed factor times on b, with a saturating backlog.
// Optional status outputs (pending_cnt, drop_cnt) are enabled by defining TOKEN_MULTIPLIER_STATUS_EN.
module token_multiplier #(
    parameter int FW          = 4,
    parameter int MAX_PENDING = 200,
    parameter int CW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    input  logic [FW-1:0] factor,
    output logic          b,
    output logic          overflow,
`ifdef TOKEN_MULTIPLIER_STATUS_EN
    output logic [CW-1:0] pending_cnt,
    output logic [15:0]   drop_cnt,
`endif
    output logic          busy
);

    localparam int SW = CW + FW + 1;

    logic [CW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic          in_tok;
    logic          have_pending;
    logic [SW-1:0] sum;
    logic          sat;

    // Output is gated by rst so nothing leaks out during the reset cycle.
    always_comb begin
        in_tok       = a & (factor != '0);
        have_pending = (pending_q != '0);
        b            = ~rst & (in_tok | have_pending);
        busy         = ~rst & have_pending;
        overflow     = overflow_q;
    end

    always_comb begin
        sum        = SW'(pending_q) + (a ? SW'(factor) : '0) - SW'(b);
        sat        = (sum > SW'(MAX_PENDING));
        pending_d  = sat ? CW'(MAX_PENDING) : sum[CW-1:0];
        overflow_d = overflow_q | sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef TOKEN_MULTIPLIER_STATUS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop_evt;

    // A drop is either a zero-factor token or a cycle whose excess was clipped by saturation.
    always_comb begin
        drop_evt   = (a & (factor == '0)) | sat;
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pending_cnt = pending_q;
    assign drop_cnt    = drop_cnt_q;
`else
    // Default build carries no status counters.
`endif

endmodule

// File: tb/tb_token_multiplier.sv
// Directed self-checking bench for token_multiplier (FW=4, MAX_PENDING=200).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_token_multiplier;

    logic       clk;
    logic       rst;
    logic       a;
    logic [3:0] factor;
    logic       b;
    logic       overflow;
    logic       busy;
`ifdef TOKEN_MULTIPLIER_STATUS_EN
    logic [7:0]  pending_cnt;
    logic [15:0] drop_cnt;
`endif

    int compared;
    int mismatched;

    token_multiplier #(.FW(4), .MAX_PENDING(200)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .factor      (factor),
        .b           (b),
        .overflow    (overflow),
`ifdef TOKEN_MULTIPLIER_STATUS_EN
        .pending_cnt (pending_cnt),
        .drop_cnt    (drop_cnt),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the next falling edge, drive the inputs, then let b settle.
    task automatic applyStimulus(input logic r, input logic av, input logic [3:0] fv);
        @(negedge clk);
        rst    = r;
        a      = av;
        factor = fv;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [25:0] t1_a;
        logic [25:0] t1_b;
        logic [63:0] t2_a;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        a          = 1'b0;
        factor     = 4'd0;
        t1_a       = 26'b10010011000110100001100100;
        t1_b       = 26'b11011011110111111001111110;
        t2_a       = 64'hB36E_05D9_A1F4_7C28;

        // Reset state
        applyStimulus(1'b1, 1'b1, 4'd2);
        checkOutput("reset_b", b, 0);
        checkOutput("reset_busy", busy, 0);
        applyStimulus(1'b0, 1'b0, 4'd2);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_idle_b", b, 0);

        // Test 1: factor=2 mixed pattern, MSB first
        for (int i = 25; i >= 0; i--) begin
            applyStimulus(1'b0, t1_a[i], 4'd2);
            checkOutput("t1_b", b, t1_b[i]);
        end
        applyStimulus(1'b0, 1'b0, 4'd2);
        checkOutput("t1_busy_end", busy, 0);
        checkOutput("t1_overflow", overflow, 0);

        // Test 2: factor=1 pass-through
        for (int i = 63; i >= 0; i--) begin
            applyStimulus(1'b0, t2_a[i], 4'd1);
            checkOutput("t2_b", b, t2_a[i]);
            checkOutput("t2_busy", busy, 0);
        end

        // Test 3: factor=3 single token
        applyStimulus(1'b0, 1'b0, 4'd3);
        applyStimulus(1'b0, 1'b1, 4'd3);
        checkOutput("t3_b0", b, 1);
        checkOutput("t3_busy0", busy, 0);
        applyStimulus(1'b0, 1'b0, 4'd3);
        checkOutput("t3_b1", b, 1);
        checkOutput("t3_busy1", busy, 1);
        applyStimulus(1'b0, 1'b0, 4'd3);
        checkOutput("t3_b2", b, 1);
        checkOutput("t3_busy2", busy, 1);
        applyStimulus(1'b0, 1'b0, 4'd3);
        checkOutput("t3_b3", b, 0);
        checkOutput("t3_busy3", busy, 0);

        // Test 4a: 200 ones at factor=2 fill the backlog exactly
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd2);
            checkOutput("t4a_b_in", b, 1);
        end
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd2);
            checkOutput("t4a_b_drain", b, 1);
            checkOutput("t4a_overflow", overflow, 0);
        end
        applyStimulus(1'b0, 1'b0, 4'd2);
        checkOutput("t4a_b_done", b, 0);
        checkOutput("t4a_busy_done", busy, 0);

        // Test 4b: the 201st one overflows
        for (int i = 0; i < 201; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd2);
            checkOutput("t4b_b_in", b, 1);
            checkOutput("t4b_overflow_pre", overflow, 0);
        end
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd2);
            checkOutput("t4b_b_drain", b, 1);
            checkOutput("t4b_overflow", overflow, 1);
        end
        applyStimulus(1'b0, 1'b0, 4'd2);
        checkOutput("t4b_b_done", b, 0);
        checkOutput("t4b_overflow_sticky", overflow, 1);
        applyStimulus(1'b0, 1'b1, 4'd1);
        checkOutput("t4b_accept_while_ovf", b, 1);
        applyStimulus(1'b1, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b0, 4'd1);
        checkOutput("t4b_overflow_cleared", overflow, 0);

        // Test 5: reset mid-burst with 10 tokens owed
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd4);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd4);
        end
`ifdef TOKEN_MULTIPLIER_STATUS_EN
        checkOutput("t5_pending_cnt", pending_cnt, 10);
`endif
        checkOutput("t5_busy_before", busy, 1);
        applyStimulus(1'b1, 1'b0, 4'd4);
        checkOutput("t5_b_in_reset", b, 0);
        checkOutput("t5_busy_in_reset", busy, 0);
        applyStimulus(1'b0, 1'b0, 4'd4);
        checkOutput("t5_b_after", b, 0);
        checkOutput("t5_busy_after", busy, 0);
        checkOutput("t5_overflow_after", overflow, 0);
        applyStimulus(1'b0, 1'b1, 4'd2);
        checkOutput("t5_tok0", b, 1);
        applyStimulus(1'b0, 1'b0, 4'd2);
        checkOutput("t5_tok1", b, 1);
        applyStimulus(1'b0, 1'b0, 4'd2);
        checkOutput("t5_tok2", b, 0);

        // Test 6: factor=0 drops every token
        applyStimulus(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd0);
            checkOutput("t6_b", b, 0);
            checkOutput("t6_busy", busy, 0);
        end
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("t6_busy_end", busy, 0);
`ifdef TOKEN_MULTIPLIER_STATUS_EN
        checkOutput("t6_drop_cnt", drop_cnt, 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
